// File: rtl/pwm_compare_deadtime.sv
// ---------------------------------------------------------------------------
// pwm_compare_deadtime
//
// Turns an external up/down count into a pair of complementary switch drives.
// A registered compare (cnt_in < duty_active) produces the raw PWM level. New
// duty values are taken through a one-deep pending slot. That slot is copied
// into duty_active on the update event, which is the first cnt_in==0 sample
// after a non-zero sample, or the first zero sample after reset.
//
// Build option: define PWM_DEADTIME_EN to insert the dead-time FSM between
// the raw compare and the outputs. Without it, pwm_hi/pwm_lo are raw/~raw and
// dead_time is accepted but ignored.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   cnt_in      count value from the upstream up/down counter (CNT_WIDTH)
//   duty_in     offered compare value (CNT_WIDTH+1); 2^CNT_WIDTH and above = 100%
//   duty_valid  duty_in is offered this cycle
//   duty_ready  pending slot is empty (offer is taken on valid & ready)
//   dead_time   both-off interval control, interval = dead_time+1 cycles
//   pwm_hi      high-side drive
//   pwm_lo      low-side drive
//   period_evt  one-cycle pulse on every update event
// ---------------------------------------------------------------------------
module pwm_compare_deadtime #(
    parameter int CNT_WIDTH = 3,
    parameter int DT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_WIDTH-1:0] cnt_in,
    input  logic [CNT_WIDTH:0]   duty_in,
    input  logic                 duty_valid,
    output logic                 duty_ready,
    input  logic [DT_WIDTH-1:0]  dead_time,
    output logic                 pwm_hi,
    output logic                 pwm_lo,
    output logic                 period_evt
);

    logic               upd_armed;
    logic               pend_full;
    logic [CNT_WIDTH:0] pend_duty;
    logic [CNT_WIDTH:0] duty_active;
    logic               raw;
    logic               cnt_zero;
    logic               upd_evt;
    logic               accept;

    // upd_armed remembers that the previous sample was non-zero (or that we
    // just left reset), so a run of zeros produces only one event.
    assign cnt_zero   = (cnt_in == '0);
    assign upd_evt    = upd_armed & cnt_zero & ~reset;
    assign period_evt = upd_evt;
    assign duty_ready = ~pend_full;
    assign accept     = duty_valid & ~pend_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_armed   <= 1'b1;
            pend_full   <= 1'b0;
            duty_active <= '0;
            raw         <= 1'b0;
        end else begin
            upd_armed <= ~cnt_zero;
            raw       <= ({1'b0, cnt_in} < duty_active);
            // A full slot blocks accepts, so an event with a full slot never
            // coincides with a new accept. An accept on an event with an
            // empty slot only fills the slot.
            if (upd_evt && pend_full) begin
                duty_active <= pend_duty;
                pend_full   <= 1'b0;
            end else if (accept) begin
                pend_full <= 1'b1;
            end
        end
    end

    // Pending data is only meaningful while pend_full is set, so it is not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_duty <= duty_in;
        end
    end

`ifdef PWM_DEADTIME_EN
    typedef enum logic [1:0] {
        DEAD_TO_LO = 2'd0,
        DEAD_TO_HI = 2'd1,
        HI_ON      = 2'd2,
        LO_ON      = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DT_WIDTH-1:0] dtcnt;
    logic [DT_WIDTH-1:0] dtcnt_nxt;
    logic [DT_WIDTH-1:0] dt_q;
    logic [DT_WIDTH-1:0] dt_lim;
    logic                dt_load;
    logic                first_cyc;

    // Leaving reset counts as entering DEAD_TO_LO. dt_q is still 0 in that
    // first cycle, so the limit comes straight from dead_time. The same
    // value is captured into dt_q at that edge.
    assign dt_lim = first_cyc ? dead_time : dt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DEAD_TO_LO;
            dtcnt     <= '0;
            dt_q      <= '0;
            first_cyc <= 1'b1;
        end else begin
            state     <= state_nxt;
            dtcnt     <= dtcnt_nxt;
            first_cyc <= 1'b0;
            if (dt_load || first_cyc) begin
                dt_q <= dead_time;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        dtcnt_nxt = dtcnt;
        dt_load   = 1'b0;
        case (state)
            DEAD_TO_LO: begin
                if (raw) begin
                    state_nxt = DEAD_TO_HI;
                    dtcnt_nxt = '0;
                    dt_load   = 1'b1;
                end else if (dtcnt == dt_lim) begin
                    state_nxt = LO_ON;
                end else begin
                    dtcnt_nxt = dtcnt + 1'b1;
                end
            end
            DEAD_TO_HI: begin
                if (!raw) begin
                    state_nxt = DEAD_TO_LO;
                    dtcnt_nxt = '0;
                    dt_load   = 1'b1;
                end else if (dtcnt == dt_lim) begin
                    state_nxt = HI_ON;
                end else begin
                    dtcnt_nxt = dtcnt + 1'b1;
                end
            end
            HI_ON: begin
                if (!raw) begin
                    state_nxt = DEAD_TO_LO;
                    dtcnt_nxt = '0;
                    dt_load   = 1'b1;
                end
            end
            LO_ON: begin
                if (raw) begin
                    state_nxt = DEAD_TO_HI;
                    dtcnt_nxt = '0;
                    dt_load   = 1'b1;
                end
            end
            default: begin
                state_nxt = DEAD_TO_LO;
                dtcnt_nxt = '0;
            end
        endcase
    end

    // Pure state decode: the two drives can never be high together.
    assign pwm_hi = (state == HI_ON);
    assign pwm_lo = (state == LO_ON);
`else
    logic unused_dead_time;

    assign unused_dead_time = ^dead_time;
    assign pwm_hi           = raw & ~reset;
    assign pwm_lo           = ~raw & ~reset;
`endif

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// ---------------------------------------------------------------------------
// tb_pwm_compare_deadtime
//
// Directed bench for pwm_compare_deadtime (CNT_WIDTH=3, DT_WIDTH=4). The bench
// drives cnt_in as a triangle count 0..7..0 with a period of 14 cycles.
// Cycle n is the n-th count presented after reset release, and that count is
// presented before the n-th rising edge. Outputs are checked 2 time units
// after the previous edge. The pwm expectations cover both builds: with
// PWM_DEADTIME_EN they follow the dead-time FSM, without it they follow the
// raw compare level.
// ---------------------------------------------------------------------------
module tb_pwm_compare_deadtime;

    logic       clk;
    logic       reset;
    logic [2:0] cnt_in;
    logic [3:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic [3:0] dead_time;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_evt;

    int         n_vec;
    int         n_err;
    int         cyc;
    logic [2:0] cnt;
    logic       up;

    pwm_compare_deadtime #(
        .CNT_WIDTH(3),
        .DT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .duty_in   (duty_in),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .dead_time (dead_time),
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo),
        .period_evt(period_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both drives high at once is never allowed, in any cycle.
    always @(negedge clk) begin
        n_vec++;
        assert (!(pwm_hi === 1'b1 && pwm_lo === 1'b1)) else begin
            n_err++;
            $error("FAIL excl pwm_hi=%b pwm_lo=%b want not both 1", pwm_hi, pwm_lo);
        end
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got %b want %b", tag, cyc, got, exp);
        end
    endtask

    // e_raw: expected compare level; dt_hi/dt_lo: expected drives with dead time.
    task automatic chk(input string tag, input logic e_raw, input logic dt_hi, input logic dt_lo);
        logic eh;
        logic el;
`ifdef PWM_DEADTIME_EN
        eh = dt_hi;
        el = dt_lo;
`else
        eh = e_raw;
        el = ~e_raw;
`endif
        chk1({tag, "_hi"}, pwm_hi, eh);
        chk1({tag, "_lo"}, pwm_lo, el);
    endtask

    // Finish the current cycle and present the next triangle count.
    task automatic step();
        @(posedge clk);
        #1;
        if (up) begin
            if (cnt == 3'd7) begin
                up  = 1'b0;
                cnt = 3'd6;
            end else begin
                cnt = cnt + 3'd1;
            end
        end else begin
            if (cnt == 3'd0) begin
                up  = 1'b1;
                cnt = 3'd1;
            end else begin
                cnt = cnt - 3'd1;
            end
        end
        cnt_in = cnt;
        cyc++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Hold reset over two edges, release just after an edge and present cycle 1.
    task automatic do_release();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cnt    = 3'd0;
        up     = 1'b1;
        cyc    = 1;
        cnt_in = cnt;
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        cnt        = 3'd0;
        up         = 1'b1;
        reset      = 1'b1;
        cnt_in     = 3'd0;
        duty_in    = 4'd0;
        duty_valid = 1'b0;
        dead_time  = 4'd2;
        #2;
        chk1("rst_hi", pwm_hi, 1'b0);
        chk1("rst_lo", pwm_lo, 1'b0);
        chk1("rst_rdy", duty_ready, 1'b1);
        chk1("rst_evt", period_evt, 1'b0);
        do_release();

        // Test 1: dead_time=2 after reset, pwm_lo after the 3rd edge.
        chk1("t1_evt_c1", period_evt, 1'b1);
        chk1("t1_rdy_c1", duty_ready, 1'b1);
        chk("t1_c1", 1'b0, 1'b0, 1'b0);
        run_to(2);  chk1("t1_evt_c2", period_evt, 1'b0);
        run_to(3);  chk("t1_c3", 1'b0, 1'b0, 1'b0);
        run_to(4);  chk("t1_c4", 1'b0, 1'b0, 1'b1);

        // Test 2: duty 3 offered at count 5, applied at the next zero.
        run_to(6);  chk1("t2_rdy_c6", duty_ready, 1'b1);
        duty_in = 4'd3; duty_valid = 1'b1;
        run_to(7);  chk1("t2_rdy_c7", duty_ready, 1'b0);
        duty_valid = 1'b0;
        run_to(14); chk1("t2_evt_c14", period_evt, 1'b0);
        run_to(15); chk1("t2_evt_c15", period_evt, 1'b1);
        chk1("t2_rdy_c15", duty_ready, 1'b0);
        run_to(16); chk1("t2_rdy_c16", duty_ready, 1'b1);
        chk1("t2_evt_c16", period_evt, 1'b0);
        run_to(17); chk("t2_c17", 1'b1, 1'b0, 1'b1);
        run_to(18); chk("t2_c18", 1'b1, 1'b0, 1'b0);
        run_to(20); chk("t2_c20", 1'b0, 1'b0, 1'b0);
        run_to(23); chk("t2_c23", 1'b0, 1'b0, 1'b1);
        run_to(29); chk("t2_c29", 1'b1, 1'b0, 1'b0);
        run_to(32); chk("t2_c32", 1'b1, 1'b1, 1'b0);
        run_to(33); chk("t2_c33", 1'b0, 1'b1, 1'b0);
        run_to(34); chk("t2_c34", 1'b0, 1'b0, 1'b0);

        // Test 3: duty 3 then duty 6 two cycles later; the second one stalls.
        chk1("t3_rdy_c34", duty_ready, 1'b1);
        duty_in = 4'd3; duty_valid = 1'b1;
        run_to(35); chk1("t3_rdy_c35", duty_ready, 1'b0);
        duty_valid = 1'b0;
        run_to(36); duty_in = 4'd6; duty_valid = 1'b1;
        chk1("t3_rdy_c36", duty_ready, 1'b0);
        run_to(37); chk("t3_c37", 1'b0, 1'b0, 1'b1);
        run_to(40); chk1("t3_rdy_c40", duty_ready, 1'b0);
        run_to(43); chk1("t3_evt_c43", period_evt, 1'b1);
        chk1("t3_rdy_c43", duty_ready, 1'b0);
        run_to(44); chk1("t3_rdy_c44", duty_ready, 1'b1);
        run_to(45); chk1("t3_rdy_c45", duty_ready, 1'b0);
        duty_valid = 1'b0;
        run_to(57); chk1("t3_evt_c57", period_evt, 1'b1);
        chk1("t3_rdy_c57", duty_ready, 1'b0);
        run_to(58); chk1("t3_rdy_c58", duty_ready, 1'b1);
        run_to(63); chk("t3_c63", 1'b1, 1'b1, 1'b0);
        run_to(64); chk("t3_c64", 1'b0, 1'b1, 1'b0);

        // Test 4: duty 8 gives 100%.
        chk1("t4_rdy_c64", duty_ready, 1'b1);
        duty_in = 4'd8; duty_valid = 1'b1;
        run_to(65); duty_valid = 1'b0;
        chk1("t4_rdy_c65", duty_ready, 1'b0);
        chk("t4_c65", 1'b0, 1'b0, 1'b0);
        run_to(71); chk1("t4_evt_c71", period_evt, 1'b1);
        run_to(72); chk1("t4_rdy_c72", duty_ready, 1'b1);
        run_to(78); chk("t4_c78", 1'b1, 1'b1, 1'b0);
        run_to(85); chk1("t4_evt_c85", period_evt, 1'b1);
        chk("t4_c85", 1'b1, 1'b1, 1'b0);
        run_to(86); chk1("t4_evt_c86", period_evt, 1'b0);

        // Test 6: reset while HI_ON with a pending duty of 2.
        chk1("t6_rdy_c86", duty_ready, 1'b1);
        duty_in = 4'd2; duty_valid = 1'b1;
        run_to(87); duty_valid = 1'b0;
        chk1("t6_rdy_c87", duty_ready, 1'b0);
        run_to(90); chk("t6_c90", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        dead_time = 4'd5;
        #1;
        chk1("t6_rst_hi", pwm_hi, 1'b0);
        chk1("t6_rst_lo", pwm_lo, 1'b0);
        chk1("t6_rst_rdy", duty_ready, 1'b1);
        chk1("t6_rst_evt", period_evt, 1'b0);
        do_release();
        chk1("t6_evt_r1", period_evt, 1'b1);
        chk1("t6_rdy_r1", duty_ready, 1'b1);
        chk("t6_r1", 1'b0, 1'b0, 1'b0);

        // Test 5: dead_time=5, duty 2. Raw is high for 1 cycle and then for
        // 3 cycles, both shorter than the 6-cycle dead interval.
        run_to(2);  chk1("t5_rdy_r2", duty_ready, 1'b1);
        duty_in = 4'd2; duty_valid = 1'b1;
        run_to(3);  duty_valid = 1'b0;
        chk1("t5_rdy_r3", duty_ready, 1'b0);
        chk("t6_r3", 1'b0, 1'b0, 1'b0);
        run_to(6);  chk("t5_r6", 1'b0, 1'b0, 1'b0);
        run_to(7);  chk("t5_r7", 1'b0, 1'b0, 1'b1);
        run_to(15); chk1("t5_evt_r15", period_evt, 1'b1);
        chk1("t5_rdy_r15", duty_ready, 1'b0);
        run_to(16); chk1("t5_rdy_r16", duty_ready, 1'b1);
        run_to(17); chk("t5_r17", 1'b1, 1'b0, 1'b1);
        run_to(18); chk("t5_r18", 1'b0, 1'b0, 1'b0);
        run_to(19); chk("t5_r19", 1'b0, 1'b0, 1'b0);
        run_to(24); chk("t5_r24", 1'b0, 1'b0, 1'b0);
        run_to(25); chk("t5_r25", 1'b0, 1'b0, 1'b1);
        run_to(29); chk("t5_r29", 1'b1, 1'b0, 1'b1);
        run_to(30); chk("t5_r30", 1'b1, 1'b0, 1'b0);
        run_to(31); chk("t5_r31", 1'b1, 1'b0, 1'b0);
        run_to(32); chk("t5_r32", 1'b0, 1'b0, 1'b0);
        run_to(33); chk("t5_r33", 1'b0, 1'b0, 1'b0);
        run_to(39); chk("t5_r39", 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
